// File: rtl/jpeg_stream_sequencer.sv
// Frame sequencer: replays the header ROM, forwards stuffed scan bytes, waits for drain, appends EOI.
// Optional: define JPEG_SEQ_BYTE_COUNT_EN to add a 32-bit byte_count output.
module jpeg_stream_sequencer #(
    parameter int HEADER_LEN  = 623,
    parameter int HDR_ADDR_W  = 10,
    parameter int DRAIN_QUIET = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [HDR_ADDR_W-1:0] header_addr,
    input  logic [7:0]            header_data,
    output logic                  scan_enable,
    input  logic                  scan_done,
    input  logic                  stuffed_valid,
    input  logic [7:0]            stuffed_data,
    input  logic                  stuffer_overflow,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error
`ifdef JPEG_SEQ_BYTE_COUNT_EN
    ,
    output logic [31:0]           byte_count
`endif
);

    localparam int CNT_W = $clog2(DRAIN_QUIET + 1);
    localparam logic [HDR_ADDR_W-1:0] LAST_ADDR  = HDR_ADDR_W'(HEADER_LEN - 1);
    localparam logic [CNT_W-1:0]      QUIET_LAST = CNT_W'(DRAIN_QUIET - 1);
    localparam logic [CNT_W-1:0]      QUIET_MAX  = CNT_W'(DRAIN_QUIET);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        HDR_LAST,
        SCAN,
        DRAIN,
        EOI_FF,
        EOI_D9
    } state_t;

    state_t                  state_q, state_d;
    logic [HDR_ADDR_W-1:0]   hdrAddr_q, hdrAddr_d;
    logic [CNT_W-1:0]        drainCnt_q, drainCnt_d;
    logic                    outValid_q, outValid_d;
    logic [7:0]              outData_q, outData_d;
    logic                    frameDone_q, frameDone_d;
    logic                    error_q, error_d;

    always_comb begin
        state_d     = state_q;
        hdrAddr_d   = hdrAddr_q;
        drainCnt_d  = drainCnt_q;
        outValid_d  = 1'b0;
        outData_d   = outData_q;
        frameDone_d = 1'b0;
        error_d     = error_q | stuffer_overflow;

        case (state_q)
            IDLE: begin
                if (stuffed_valid) error_d = 1'b1;
                if (start) begin
                    state_d   = HEADER;
                    hdrAddr_d = '0;
                end
            end
            HEADER: begin
                // ROM data arriving now belongs to the address issued last cycle
                outValid_d = 1'b1;
                outData_d  = header_data;
                if (stuffed_valid) error_d = 1'b1;
                if (hdrAddr_q == LAST_ADDR) begin
                    state_d = HDR_LAST;
                end else begin
                    hdrAddr_d = hdrAddr_q + HDR_ADDR_W'(1);
                end
            end
            HDR_LAST: begin
                if (stuffed_valid) error_d = 1'b1;
                state_d = SCAN;
            end
            SCAN: begin
                outValid_d = stuffed_valid;
                if (stuffed_valid) outData_d = stuffed_data;
                if (scan_done) begin
                    state_d    = DRAIN;
                    drainCnt_d = '0;
                end
            end
            DRAIN: begin
                outValid_d = stuffed_valid;
                if (stuffed_valid) begin
                    outData_d  = stuffed_data;
                    drainCnt_d = '0;
                end else if (drainCnt_q == QUIET_LAST) begin
                    state_d = EOI_FF;
                end else if (drainCnt_q != QUIET_MAX) begin
                    drainCnt_d = drainCnt_q + CNT_W'(1);
                end
            end
            EOI_FF: begin
                if (stuffed_valid) error_d = 1'b1;
                outValid_d = 1'b1;
                outData_d  = 8'hFF;
                state_d    = EOI_D9;
            end
            EOI_D9: begin
                if (stuffed_valid) error_d = 1'b1;
                outValid_d  = 1'b1;
                outData_d   = 8'hD9;
                frameDone_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The ROM is driven from the next address so it is one read ahead of the state register
        if (reset) hdrAddr_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            hdrAddr_q   <= '0;
            drainCnt_q  <= '0;
            outValid_q  <= 1'b0;
            outData_q   <= 8'h00;
            frameDone_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdrAddr_q   <= hdrAddr_d;
            drainCnt_q  <= drainCnt_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            frameDone_q <= frameDone_d;
            error_q     <= error_d;
        end
    end

    assign header_addr = hdrAddr_d;
    assign scan_enable = (state_q == SCAN);
    assign busy        = (state_q != IDLE);
    assign out_valid   = outValid_q;
    assign out_data    = outData_q;
    assign frame_done  = frameDone_q;
    assign error       = error_q;

`ifdef JPEG_SEQ_BYTE_COUNT_EN
    logic [31:0] byteCount_q, byteCount_d;

    always_comb begin
        byteCount_d = byteCount_q + {31'd0, outValid_q};
        if (state_q == IDLE && start) byteCount_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byteCount_q <= '0;
        end else begin
            byteCount_q <= byteCount_d;
        end
    end

    assign byte_count = byteCount_q;
`endif

endmodule
